// File: rtl/time_set_ctrl.sv
// time_set_ctrl: mode and sequencing controller for the digital-clock timer.
// Owns the BCD seconds count, sequences RUN / SET_MIN / SET_HOUR, and issues
// one-cycle advance strobes to the minute and hour counters, including
// hold-to-repeat and an inactivity timeout while in a set mode.
module time_set_ctrl #(
   parameter int HOLD_TICKS    = 2,
   parameter int TIMEOUT_TICKS = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_1hz,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic [1:0] mode,
   output logic [3:0] sec_low,
   output logic [3:0] sec_high,
   output logic       min_adv,
   output logic       hour_adv,
   output logic       blink
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_SET_MIN  = 2'd1,
      ST_SET_HOUR = 2'd2
   } state_t;

   // Hold count at which auto-repeat becomes active.
   localparam logic [3:0] HOLD_LAST_C = 4'(HOLD_TICKS);
   // Idle count that, when one more tick arrives, reaches the timeout.
   localparam logic [5:0] IDLE_LAST_C = 6'(TIMEOUT_TICKS - 1);

   state_t      state_r;
   logic [3:0]  sec_low_r;
   logic [3:0]  sec_high_r;
   logic        min_adv_r;
   logic        hour_adv_r;
   logic        blink_r;
   logic [3:0]  hold_cnt_r;
   logic [5:0]  idle_cnt_r;
   logic        mode_prev_r;
   logic        inc_prev_r;

   logic        mode_rise_s;
   logic        inc_rise_s;
   logic        repeat_s;
   logic        timeout_s;

   // Button edge detection, auto-repeat and timeout qualification.
   always_comb begin
      mode_rise_s = btn_mode & ~mode_prev_r;
      inc_rise_s  = btn_inc & ~inc_prev_r;
      repeat_s    = 1'b0;
      timeout_s   = 1'b0;
      if (state_r != ST_RUN) begin
         repeat_s  = tick_1hz & btn_inc & (hold_cnt_r == HOLD_LAST_C);
         // Any advance this tick clears the idle count, so it cannot time out.
         timeout_s = tick_1hz & (idle_cnt_r == IDLE_LAST_C) & ~(inc_rise_s | repeat_s);
      end else begin
         repeat_s  = 1'b0;
         timeout_s = 1'b0;
      end
   end

   // Mode FSM, seconds counter, hold/idle counters and registered strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_RUN;
         sec_low_r   <= 4'd0;
         sec_high_r  <= 4'd0;
         min_adv_r   <= 1'b0;
         hour_adv_r  <= 1'b0;
         blink_r     <= 1'b0;
         hold_cnt_r  <= 4'd0;
         idle_cnt_r  <= 6'd0;
         mode_prev_r <= 1'b0;
         inc_prev_r  <= 1'b0;
      end else begin
         mode_prev_r <= btn_mode;
         inc_prev_r  <= btn_inc;
         min_adv_r   <= 1'b0;
         hour_adv_r  <= 1'b0;
         case (state_r)
            ST_RUN: begin
               hold_cnt_r <= 4'd0;
               idle_cnt_r <= 6'd0;
               if (mode_rise_s) begin
                  // Entering SET_MIN: seconds freeze at 00, field starts visible.
                  state_r    <= ST_SET_MIN;
                  sec_low_r  <= 4'd0;
                  sec_high_r <= 4'd0;
                  blink_r    <= 1'b1;
               end else if (tick_1hz) begin
                  blink_r <= 1'b0;
                  if (sec_low_r == 4'd9) begin
                     sec_low_r <= 4'd0;
                     if (sec_high_r == 4'd5) begin
                        sec_high_r <= 4'd0;
                        min_adv_r  <= 1'b1;
                     end else begin
                        sec_high_r <= sec_high_r + 4'd1;
                     end
                  end else begin
                     sec_low_r <= sec_low_r + 4'd1;
                  end
               end else begin
                  blink_r <= 1'b0;
               end
            end
            ST_SET_MIN, ST_SET_HOUR: begin
               sec_low_r  <= 4'd0;
               sec_high_r <= 4'd0;
               if (mode_rise_s) begin
                  // Mode change wins over increment and timeout in the same cycle.
                  hold_cnt_r <= 4'd0;
                  idle_cnt_r <= 6'd0;
                  if (state_r == ST_SET_MIN) begin
                     state_r <= ST_SET_HOUR;
                     blink_r <= 1'b1;
                  end else begin
                     state_r <= ST_RUN;
                     blink_r <= 1'b0;
                  end
               end else if (timeout_s) begin
                  state_r    <= ST_RUN;
                  blink_r    <= 1'b0;
                  hold_cnt_r <= 4'd0;
                  idle_cnt_r <= 6'd0;
               end else begin
                  if (inc_rise_s | repeat_s) begin
                     if (state_r == ST_SET_MIN) begin
                        min_adv_r <= 1'b1;
                     end else begin
                        hour_adv_r <= 1'b1;
                     end
                     idle_cnt_r <= 6'd0;
                  end else if (tick_1hz) begin
                     idle_cnt_r <= idle_cnt_r + 6'd1;
                  end else begin
                     idle_cnt_r <= idle_cnt_r;
                  end
                  // Hold counter saturates at HOLD_TICKS while the button stays down.
                  if (!btn_inc) begin
                     hold_cnt_r <= 4'd0;
                  end else if (tick_1hz && (hold_cnt_r != HOLD_LAST_C)) begin
                     hold_cnt_r <= hold_cnt_r + 4'd1;
                  end else begin
                     hold_cnt_r <= hold_cnt_r;
                  end
                  if (tick_1hz) begin
                     blink_r <= ~blink_r;
                  end else begin
                     blink_r <= blink_r;
                  end
               end
            end
            default: begin
               state_r    <= ST_RUN;
               sec_low_r  <= 4'd0;
               sec_high_r <= 4'd0;
               blink_r    <= 1'b0;
               hold_cnt_r <= 4'd0;
               idle_cnt_r <= 6'd0;
            end
         endcase
      end
   end

   assign mode     = state_r;
   assign sec_low  = sec_low_r;
   assign sec_high = sec_high_r;
   assign min_adv  = min_adv_r;
   assign hour_adv = hour_adv_r;
   assign blink    = blink_r;

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Mode and sequencing controller for the digital-clock timer. It owns the seconds count (BCD 00–59) and issues one-cycle advance strobes to the minute and hour counters. In RUN it generates a minute strobe on every seconds wrap. In the two set modes it freezes seconds and turns debounced push-button presses into minute or hour advance strobes, with hold-to-repeat and an inactivity timeout.

## Interface
Parameters:
- HOLD_TICKS, default 2: ticks btn_inc must be held before auto-repeat starts (valid range 1..15).
- TIMEOUT_TICKS, default 10: idle ticks in a set mode before automatic return to RUN (valid range 1..63).

Ports (all on one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick_1hz  in  1  one-clk-cycle pulse, once per second
- btn_mode  in  1  debounced mode button, level, synchronous to clk
- btn_inc  in  1  debounced increment button, level, synchronous to clk
- mode  out  2  0 = RUN, 1 = SET_MIN, 2 = SET_HOUR (3 is never driven)
- sec_low  out  4  seconds units, BCD 0..9
- sec_high  out  4  seconds tens, BCD 0..5
- min_adv  out  1  one-cycle strobe: advance the minute counter by one
- hour_adv  out  1  one-cycle strobe: advance the hour counter by one
- blink  out  1  display blank/flash enable for the field being set

## Operation
- Edge detection: registered copies of btn_mode and btn_inc. A rise is current = 1 and previous = 0. Both previous registers reset to 0.
- Mode FSM:
  - RUN → SET_MIN on a btn_mode rise.
  - SET_MIN → SET_HOUR on a btn_mode rise.
  - SET_HOUR → RUN on a btn_mode rise.
  - SET_MIN or SET_HOUR → RUN when the idle count reaches TIMEOUT_TICKS.
- Seconds, RUN mode:
  - On tick_1hz, sec_low increments.
  - At 9, sec_low wraps to 0 and sec_high increments.
  - At 59, both wrap to 00 and min_adv is strobed.
- Seconds, on leaving RUN: cleared to 00.
- Seconds, in a set mode: held at 00 and ticks are ignored.
- Seconds, on returning to RUN: counting resumes from 00.
- Increment in a set mode: a btn_inc rise strobes min_adv in SET_MIN or hour_adv in SET_HOUR. No strobes of either kind are issued from btn_inc in RUN.
- Auto-repeat, in a set mode while btn_inc = 1:
  - The hold counter increments on each tick, saturating at HOLD_TICKS.
  - Once the counter equals HOLD_TICKS, each further tick while the button is held strobes the active advance output.
  - The hold counter clears when btn_inc = 0 or the mode changes.
- Idle counter, set modes only:
  - Increments on each tick.
  - Clears on any button rise, on any auto-repeat strobe, and on mode entry.
  - Timeout fires when the counter equals TIMEOUT_TICKS.
- Blink:
  - 0 in RUN.
  - Set to 1 on entry to a set mode.
  - Toggles on each tick while in a set mode.
- Priority within one cycle:
  - A btn_mode rise beats a btn_inc rise; the increment is discarded.
  - A btn_mode rise beats the timeout, so only one transition occurs.
  - A timeout and an auto-repeat on the same tick: the auto-repeat wins and the idle count clears.
  - min_adv and hour_adv are never high in the same cycle.
- Reset mid-operation: all state returns to the reset values immediately; any strobe in flight is dropped.

## Timing
- Reset values:
  - mode = 0, sec_low = 0, sec_high = 0
  - min_adv = 0, hour_adv = 0, blink = 0
  - hold counter = 0, idle counter = 0
- All outputs are registered.
- A strobe rises on the clk edge that samples its cause (a tick or a button rise) and falls on the next edge. It lasts exactly one cycle.
- Button latency:
  - A button level change is sampled at edge k.
  - The rise is detected at edge k.
  - The resulting strobe or mode change is visible after edge k.
- A button held high produces exactly one rise and no further rises until it is released for at least one cycle.
- tick_1hz is guaranteed high for exactly one cycle. Back-to-back ticks (1 cycle apart) must still be counted correctly.
- The seconds wrap and min_adv occur on the same edge: sec reads 00 while min_adv = 1.

## Test plan
- Reset then 60 ticks in RUN → sec counts 00..59 then 00; exactly one min_adv pulse, one cycle wide, on the 60th tick; hour_adv stays 0.
- At sec = 37, btn_mode rise → mode = 1, sec = 00, blink = 1. Three separate btn_inc presses → three min_adv pulses. Ticks → sec stays 00 and blink toggles each tick.
- In SET_HOUR, hold btn_inc for 6 ticks with HOLD_TICKS = 2 → one hour_adv at the press, then one hour_adv on each of ticks 3 to 6 (4 more), 5 in total; release → no further strobes.
- In SET_MIN, no activity for 10 ticks → mode = 0 after the 10th tick, blink = 0, and seconds resume counting 00, 01, ...
- btn_mode and btn_inc rise in the same cycle in SET_MIN → mode = 2 and no min_adv or hour_adv strobe.
- Assert rst_n = 0 asynchronously mid-cycle while in SET_HOUR with a strobe pending → all outputs drop to reset values without waiting for a clk edge.
